// File: rtl/fmul_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Holds the FP width, the FSM state encoding and an index-width helper.
package fmul_arb_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Bits needed to index v items (at least 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/fmul_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req, ptr in; gnt_onehot, gnt_idx out (zero when no request).
module fmul_rr_pick
    import fmul_arb_pkg::*;
#(
    parameter int N  = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found;
    int             sum;

    // Rotate so ptr lands on bit 0, pick lowest, rotate the index back.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        sum        = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = k + int'(ptr);
                if (sum >= N) sum = sum - N;
                gnt_idx    = IW'(sum);
                gnt_onehot = N'(1) << sum;
            end
        end
    end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one external FP multiplier among N requesters, one op at a time.
// Ports: req_* handshake in, resp_* result out, mul_* to/from multiplier, busy.
module fmul_share_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    input  logic [N*FP_W-1:0] req_a,
    input  logic [N*FP_W-1:0] req_b,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      resp_valid,
    output logic [FP_W-1:0]   resp_data,
    input  logic [N-1:0]      resp_ready,
    output logic [FP_W-1:0]   mul_in1,
    output logic [FP_W-1:0]   mul_in2,
    input  logic [FP_W-1:0]   mul_out,
    output logic              busy
);

    localparam int IW = clog2(N);
    localparam int CW = clog2(MUL_LAT + 1);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [CW-1:0] cnt;

    logic [N-1:0]  gnt_onehot;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] ptr_nxt;

    fmul_rr_pick #(.N(N)) u_pick (
        .req        (req_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign ptr_nxt = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            mul_in1    <= '0;
            mul_in2    <= '0;
            busy       <= 1'b0;
        end else begin
            req_ready <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready <= gnt_onehot;
                        mul_in1   <= req_a[int'(gnt_idx)*FP_W +: FP_W];
                        mul_in2   <= req_b[int'(gnt_idx)*FP_W +: FP_W];
                        owner     <= gnt_idx;
                        ptr       <= ptr_nxt;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= CW'(MUL_LAT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        resp_data  <= mul_out;
                        resp_valid <= N'(1) << owner;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Only the owner's ready bit can retire the result.
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed self-checking bench for fmul_share_arbiter with N=4, MUL_LAT=2.
// Contains a behavioural pipelined single-precision multiplier as the shared unit.
module tb_fmul_share_arbiter;
    import fmul_arb_pkg::*;

    localparam int N       = 4;
    localparam int MUL_LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*FP_W-1:0] req_a = '0;
    logic [N*FP_W-1:0] req_b = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [FP_W-1:0]   resp_data;
    logic [N-1:0]      resp_ready = '0;
    logic [FP_W-1:0]   mul_in1;
    logic [FP_W-1:0]   mul_in2;
    logic [FP_W-1:0]   mul_out;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fmul_share_arbiter #(.N(N), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .mul_in1    (mul_in1),
        .mul_in2    (mul_in2),
        .mul_out    (mul_out),
        .busy       (busy)
    );

    // Normal-number single-precision multiply, round to nearest even.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        logic [22:0] m;
        logic        g;
        logic        st;
        logic [23:0] r;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            m = p[45:23]; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) begin
            r = {1'b0, m} + 24'd1;
            if (r[23]) begin
                m = '0; e = e + 1;
            end else begin
                m = r[22:0];
            end
        end
        return {s, e[7:0], m};
    endfunction

    logic [31:0] pipe [MUL_LAT];
    always @(posedge clk) begin
        pipe[0] <= fmul(mul_in1, mul_in2);
        for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_out = pipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*FP_W +: FP_W] = a;
        req_b[i*FP_W +: FP_W] = b;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (req_ready != '0) begin
                check("ready_onehot", 64'($countones(req_ready)), 64'd1);
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                req_valid = req_valid & ~req_ready;
                return;
            end
        end
        check("grant_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_rv();
        int c;
        c = 0;
        while (resp_valid == '0 && c < 30) begin
            tick();
            c++;
        end
        if (resp_valid == '0) check("resp_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_resp(input int own, input logic [31:0] d);
        wait_rv();
        check("resp_valid", 64'(resp_valid), 64'(N'(1) << own));
        check("resp_data", 64'(resp_data), 64'(d));
        resp_ready = N'(1) << own;
        tick();
        resp_ready = '0;
        check("resp_drop", 64'(resp_valid), 64'd0);
    endtask

    logic [31:0] pa [N];
    logic [31:0] pr [N];
    int g;
    int lat;

    initial begin
        pa[0] = 32'h40000000; pr[0] = 32'h40400000;
        pa[1] = 32'h40400000; pr[1] = 32'h40900000;
        pa[2] = 32'h40800000; pr[2] = 32'h40C00000;
        pa[3] = 32'h3F000000; pr[3] = 32'h3F400000;

        // reset state
        tick(); tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_mul_in1", 64'(mul_in1), 64'd0);
        check("rst_mul_in2", 64'(mul_in2), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        tick();

        // single op
        set_op(0, 32'h415A0000, 32'hBE200000);
        req_valid = 4'b0001;
        tick();
        check("t1_ready", 64'(req_ready), 64'b0001);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_in1", 64'(mul_in1), 64'h415A0000);
        check("t1_in2", 64'(mul_in2), 64'hBE200000);
        req_valid = '0;
        tick();
        check("t1_pulse", 64'(req_ready), 64'd0);
        lat = 1;
        while (resp_valid == '0 && lat < 20) begin
            tick();
            lat++;
        end
        check("t1_latency", 64'(lat), 64'(MUL_LAT + 1));
        wait_resp(0, 32'hC0084000);
        tick();
        check("t1_idle", 64'(busy), 64'd0);

        // contention after reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, pa[i], 32'h3FC00000);
        req_valid = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_grant(g);
            check("t2_order", 64'(g), 64'(k));
            wait_resp(k, pr[k]);
        end
        req_valid = 4'b1001;
        wait_grant(g);
        check("t2_second_a", 64'(g), 64'd0);
        wait_resp(0, pr[0]);
        wait_grant(g);
        check("t2_second_b", 64'(g), 64'd3);
        wait_resp(3, pr[3]);

        // backpressure
        req_valid = 4'b0010;
        wait_grant(g);
        check("t3_grant", 64'(g), 64'd1);
        wait_rv();
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            check("t3_hold_valid", 64'(resp_valid), 64'b0010);
            check("t3_hold_data", 64'(resp_data), 64'(pr[1]));
            check("t3_no_ready", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        check("t3_release", 64'(resp_valid), 64'd0);
        check("t3_idle", 64'(busy), 64'd0);
        wait_grant(g);
        check("t3_next", 64'(g), 64'd2);
        wait_resp(2, pr[2]);

        // wrong-owner ready
        req_valid = 4'b0100;
        wait_grant(g);
        check("t4_grant", 64'(g), 64'd2);
        wait_rv();
        resp_ready = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_stay", 64'(resp_valid), 64'b0100);
            check("t4_busy", 64'(busy), 64'd1);
        end
        resp_ready = '0;
        wait_resp(2, pr[2]);

        // operand hold
        set_op(0, pa[0], 32'h3FC00000);
        req_valid = 4'b0001;
        wait_grant(g);
        check("t6_grant", 64'(g), 64'd0);
        tick();
        req_a[0 +: FP_W] = 32'h40800000;
        tick();
        check("t6_in1", 64'(mul_in1), 64'(pa[0]));
        wait_resp(0, pr[0]);

        // reset mid-wait
        set_op(1, pa[1], 32'h3FC00000);
        req_valid = 4'b0010;
        wait_grant(g);
        check("t5_grant", 64'(g), 64'd1);
        tick();
        check("t5_in_wait", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("t5_req_ready", 64'(req_ready), 64'd0);
        check("t5_resp_valid", 64'(resp_valid), 64'd0);
        check("t5_resp_data", 64'(resp_data), 64'd0);
        check("t5_mul_in1", 64'(mul_in1), 64'd0);
        check("t5_mul_in2", 64'(mul_in2), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("t5_no_resp", 64'(resp_valid), 64'd0);
        for (int i = 0; i < N; i++) set_op(i, pa[i], 32'h3FC00000);
        req_valid = 4'b1011;
        wait_grant(g);
        check("t5_first", 64'(g), 64'd0);
        req_valid = '0;
        wait_resp(0, pr[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
